fp_div_arbiter: RTL and testbench

Round-robin arbiter that shares one iterative single-precision divider (`fp_div_iterative`) among `NUM_REQ` requesters. It accepts one operand pair at a time, issues it to the divider, waits for completion and returns the quotient to the owning requester, so the divider sees at most one operation in flight. It sits between the per-lane FP clients and the shared divider instance.

---
 rtl/fp_div_arb_pkg.sv | 7 +
 rtl/fp_div_arbiter_rr_grant.sv | 35 +++
 rtl/fp_div_arbiter.sv | 143 ++++++++++++++
 tb/tb_fp_div_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_arb_pkg.sv
// Shared types and constants for the FP divider arbiter.
package fp_div_arb_pkg;
  localparam int OP_W = 32;
  localparam logic [OP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/fp_div_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker. Grants the first set req bit
// at or after ptr, wrapping around.
module rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any
);

  // Walk the requesters starting at ptr; first hit wins.
  always_comb begin
    int j;
    logic [PTR_W-1:0] jj;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    jj        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = PTR_W'(j);
      if (!any && req[jj]) begin
        grant[jj] = 1'b1;
        grant_idx = jj;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: shares one iterative FP divider among NUM_REQ lanes,
// one operation in flight at a time, round-robin fair.
// Optional watchdog in WAIT: define FP_DIV_ARB_TIMEOUT_EN.
// The divider instance itself lives outside; its rst_n is ~rst.
module fp_div_arbiter
  import fp_div_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [OP_W*NUM_REQ-1:0] req_a,
  input  logic [OP_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [OP_W-1:0]         rsp_result,
  output logic                    rsp_err,
  output logic                    busy,
  input  logic                    div_ready,
  output logic                    div_valid_in,
  output logic [OP_W-1:0]         div_a,
  output logic [OP_W-1:0]         div_b,
  input  logic                    div_valid_out,
  input  logic [OP_W-1:0]         div_result
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state, state_n;
  logic [PTR_W-1:0]   rr_ptr, owner, grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               any, take, done, tmo_hit;
  logic [OP_W-1:0]    sel_a, sel_b;

  rr_grant #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Grant only from IDLE with the divider free; handshake equals the grant.
  assign take = (state == IDLE) && div_ready && any;
  assign done = (state == WAIT) && div_valid_out;

`ifdef FP_DIV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  // Cycles spent in WAIT for the current operation; zero elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 tmo_cnt <= '0;
    else if (state == WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
    else                     tmo_cnt <= '0;
  end

  assign tmo_hit = (state == WAIT) && !div_valid_out &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;

  // Error flag: set by watchdog expiry, cleared by a real completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (done)    err_q <= 1'b0;
    else if (tmo_hit) err_q <= 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Operand mux for the granted lane.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*OP_W +: OP_W];
        sel_b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and handshake/strobe outputs.
  always_comb begin
    state_n      = state;
    req_ready    = '0;
    rsp_valid    = '0;
    div_valid_in = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (take) begin
          req_ready = grant;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        div_valid_in = 1'b1;
        state_n      = WAIT;
      end
      WAIT: begin
        if (done || tmo_hit) state_n = RESP;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        state_n          = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, owner, pointer advance and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_a      <= '0;
      div_b      <= '0;
      owner      <= '0;
      rr_ptr     <= '0;
      rsp_result <= '0;
    end else begin
      if (take) begin
        div_a  <= sel_a;
        div_b  <= sel_b;
        owner  <= grant_idx;
        rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (done)         rsp_result <= div_result;
      else if (tmo_hit) rsp_result <= FP_QNAN;
    end
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Bench for fp_div_arbiter: stub divider with programmable latency, a
// monitor recording grants/responses, and per-scenario tasks checking them
// against a round-robin reference model.
module tb_fp_div_arbiter;
  localparam int N = 4;
  localparam int TMO = 200;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [31:0]     rsp_result, div_a, div_b;
  logic            rsp_err, busy, div_ready, div_valid_in;
  logic            div_valid_out = 1'b0;
  logic [31:0]     div_result = '0;

  int errors = 0, checks = 0, cyc = 0;

  fp_div_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .busy(busy), .div_ready(div_ready),
    .div_valid_in(div_valid_in), .div_a(div_a), .div_b(div_b),
    .div_valid_out(div_valid_out), .div_result(div_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Quotient produced by the stub divider.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40C00000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h40400000}: return 32'h3EAAAAAB;
      {32'h00000000, 32'h40A00000}: return 32'h00000000;
      {32'h40A00000, 32'h00000000}: return 32'h7F800000;
      default: return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000;
    endcase
  endfunction

  // Stub divider: one op at a time, fixed or random latency, can go mute.
  logic stub_busy = 0, stub_mute = 0, force_low = 0, stub_rand = 0;
  int   stub_cnt = 0, stub_lat = 3;
  logic [31:0] stub_a = '0, stub_b = '0;
  assign div_ready = !stub_busy && !force_low;

  always @(posedge clk) begin
    #1;
    div_valid_out = 1'b0;
    if (stub_busy && !stub_mute) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        div_valid_out = 1'b1;
        div_result    = ref_div(stub_a, stub_b);
        stub_busy     = 1'b0;
      end
    end
    if (div_valid_in) begin
      stub_busy = 1'b1;
      stub_a    = div_a;
      stub_b    = div_b;
      stub_cnt  = stub_rand ? int'($urandom_range(1, 6)) : stub_lat;
    end
  end

  // Monitor
  typedef struct {int lane; logic [N-1:0] mask; logic [31:0] a; logic [31:0] b; int cyc;} gr_t;
  typedef struct {logic [N-1:0] oh; logic [31:0] res; logic err; int cyc;} rs_t;
  gr_t gq[$];
  rs_t rq[$];
  int issues = 0, multi_rdy = 0, bad_rdy = 0;
  logic [N-1:0] hs_mask = '0;

  always @(negedge clk) begin
    hs_mask = req_ready & req_valid;
    if ($countones(req_ready) > 1) multi_rdy++;
    if (req_ready != '0 && (!div_ready || busy)) bad_rdy++;
    if (div_valid_in) issues++;
    for (int i = 0; i < N; i++)
      if (hs_mask[i]) gq.push_back('{i, req_valid, req_a[i*32 +: 32], req_b[i*32 +: 32], cyc});
    if (rsp_valid != '0) rq.push_back('{rsp_valid, rsp_result, rsp_err, cyc});
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    gq.delete(); rq.delete(); issues = 0; multi_rdy = 0; bad_rdy = 0;
  endtask

  task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_valid[i]      = 1'b1;
  endtask

  // Step until n responses, withdrawing granted lanes unless hold is set.
  task automatic run_until(input int n, input int budget, input bit hold);
    for (int k = 0; k < budget && rq.size() < n; k++) begin
      step(1);
      if (!hold) req_valid = req_valid & ~hs_mask;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && (busy || stub_busy); k++) step(1);
  endtask

  task automatic do_reset();
    req_valid = '0;
    drain();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    clear_mon();
  endtask

  task automatic test_reset();
    step(3);
    checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_err, busy, div_valid_in, div_a, div_b} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h expected all zero",
               {req_ready, rsp_valid, rsp_result, rsp_err, busy, div_valid_in, div_a, div_b});
    end
    rst = 1'b0;
    step(2);
    checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_err, busy, div_valid_in, div_a, div_b} !== '0) begin
      errors++;
      $display("FAIL reset_idle: outputs=%h expected all zero",
               {req_ready, rsp_valid, rsp_result, rsp_err, busy, div_valid_in, div_a, div_b});
    end
  endtask

  task automatic test_all_four();
    logic [31:0] ea[N] = '{32'h40400000, 32'h3EAAAAAB, 32'h00000000, 32'h7F800000};
    logic [N-1:0] oh;
    do_reset();
    stub_lat = 4;
    set_lane(0, 32'h40C00000, 32'h40000000);
    set_lane(1, 32'h3F800000, 32'h40400000);
    set_lane(2, 32'h00000000, 32'h40A00000);
    set_lane(3, 32'h40A00000, 32'h00000000);
    run_until(N, 100, 1'b0);
    step(3);
    checks++;
    if (rq.size() != N || gq.size() != N) begin
      errors++;
      $display("FAIL all4_count: rsp=%0d grants=%0d expected %0d", rq.size(), gq.size(), N);
    end
    for (int i = 0; i < N && i < rq.size(); i++) begin
      oh = N'(1) << i;
      checks++;
      if (rq[i].oh !== oh || rq[i].res !== ea[i] || rq[i].err !== 1'b0) begin
        errors++;
        $display("FAIL all4_rsp%0d: oh=%b res=%h err=%b expected oh=%b res=%h err=0",
                 i, rq[i].oh, rq[i].res, rq[i].err, oh, ea[i]);
      end
    end
    checks++;
    if (issues != N) begin
      errors++;
      $display("FAIL all4_issues: got %0d expected %0d", issues, N);
    end
  endtask

  task automatic test_single();
    clear_mon();
    stub_lat = 3;
    set_lane(0, 32'h40C00000, 32'h40000000);
    run_until(1, 40, 1'b0);
    step(2);
    checks++;
    if (gq.size() != 1 || rq.size() != 1) begin
      errors++;
      $display("FAIL single_count: grants=%0d rsp=%0d expected 1/1", gq.size(), rq.size());
    end else begin
      checks++;
      if (gq[0].lane != 0 || rq[0].oh !== 4'b0001 || rq[0].res !== 32'h40400000 || rq[0].err !== 1'b0) begin
        errors++;
        $display("FAIL single_rsp: lane=%0d oh=%b res=%h err=%b expected 0/0001/40400000/0",
                 gq[0].lane, rq[0].oh, rq[0].res, rq[0].err);
      end
      // grant T, issue T+1, divider done T+1+lat, rsp T+2+lat
      checks++;
      if (rq[0].cyc - gq[0].cyc != stub_lat + 2) begin
        errors++;
        $display("FAIL single_latency: got %0d expected %0d", rq[0].cyc - gq[0].cyc, stub_lat + 2);
      end
    end
    checks++;
    if (issues != 1) begin
      errors++;
      $display("FAIL single_issues: got %0d expected 1", issues);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    stub_lat = 2;
    set_lane(0, 32'h41200000, 32'h40800000);
    set_lane(2, 32'h42C80000, 32'h41200000);
    run_until(6, 120, 1'b1);
    req_valid = '0;
    drain();
    checks++;
    if (gq.size() < 6) begin
      errors++;
      $display("FAIL alt_count: grants=%0d expected >=6", gq.size());
    end
    for (int k = 0; k < 6 && k < gq.size(); k++) begin
      checks++;
      if (gq[k].lane != ((k % 2 == 0) ? 0 : 2)) begin
        errors++;
        $display("FAIL alt_grant%0d: lane=%0d expected %0d", k, gq[k].lane, (k % 2 == 0) ? 0 : 2);
      end
    end
    checks++;
    if (multi_rdy != 0) begin
      errors++;
      $display("FAIL alt_multi_ready: cycles=%0d expected 0", multi_rdy);
    end
  endtask

  task automatic test_ready_low();
    logic [31:0] a = $urandom, b = $urandom;
    clear_mon();
    force_low = 1'b1;
    set_lane(1, a, b);
    step(12);
    checks++;
    if (gq.size() != 0 || issues != 0 || bad_rdy != 0) begin
      errors++;
      $display("FAIL rdylow_hold: grants=%0d issues=%0d bad_ready=%0d expected 0/0/0",
               gq.size(), issues, bad_rdy);
    end
    force_low = 1'b0;
    run_until(1, 40, 1'b0);
    checks++;
    if (gq.size() != 1 || rq.size() != 1) begin
      errors++;
      $display("FAIL rdylow_count: grants=%0d rsp=%0d expected 1/1", gq.size(), rq.size());
    end else begin
      checks++;
      if (gq[0].lane != 1 || rq[0].oh !== 4'b0010 || rq[0].res !== ref_div(a, b)) begin
        errors++;
        $display("FAIL rdylow_rsp: lane=%0d oh=%b res=%h expected 1/0010/%h",
                 gq[0].lane, rq[0].oh, rq[0].res, ref_div(a, b));
      end
    end
  endtask

  task automatic test_reset_wait();
    do_reset();
    stub_lat = 12;
    set_lane(2, $urandom, $urandom);
    for (int k = 0; k < 20 && gq.size() == 0; k++) step(1);
    req_valid = '0;
    step(3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_busy: got %b expected 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_err, busy, div_valid_in, div_a, div_b} !== '0) begin
      errors++;
      $display("FAIL rstwait_async: outputs=%h expected all zero",
               {req_ready, rsp_valid, rsp_result, rsp_err, busy, div_valid_in, div_a, div_b});
    end
    step(2);
    rst = 1'b0;
    rq.delete();
    step(20);
    checks++;
    if (rq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_norsp: rsp=%0d busy=%b expected 0/0", rq.size(), busy);
    end
  endtask

  task automatic test_random();
    int p, exp_lane;
    logic [N-1:0] oh;
    do_reset();
    stub_rand = 1'b1;
    for (int k = 0; k < 2000 && gq.size() < 40; k++) begin
      step(1);
      req_valid = req_valid & ~hs_mask;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) set_lane(i, $urandom, $urandom);
        else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      end
    end
    req_valid = '0;
    drain();
    stub_rand = 1'b0;
    checks++;
    if (gq.size() < 10 || rq.size() != gq.size() || issues != gq.size()) begin
      errors++;
      $display("FAIL rand_count: grants=%0d rsp=%0d issues=%0d expected equal and >=10",
               gq.size(), rq.size(), issues);
    end
    p = 0;
    for (int k = 0; k < gq.size() && k < rq.size(); k++) begin
      exp_lane = -1;
      for (int o = 0; o < N && exp_lane < 0; o++)
        if (gq[k].mask[(p + o) % N]) exp_lane = (p + o) % N;
      checks++;
      if (gq[k].lane != exp_lane) begin
        errors++;
        $display("FAIL rand_grant%0d: lane=%0d expected %0d", k, gq[k].lane, exp_lane);
      end
      p = (gq[k].lane + 1) % N;
      oh = N'(1) << gq[k].lane;
      checks++;
      if (rq[k].oh !== oh || rq[k].res !== ref_div(gq[k].a, gq[k].b) || rq[k].err !== 1'b0) begin
        errors++;
        $display("FAIL rand_rsp%0d: oh=%b res=%h err=%b expected %b/%h/0",
                 k, rq[k].oh, rq[k].res, rq[k].err, oh, ref_div(gq[k].a, gq[k].b));
      end
    end
    checks++;
    if (multi_rdy != 0 || bad_rdy != 0) begin
      errors++;
      $display("FAIL rand_ready_rules: multi=%0d bad=%0d expected 0/0", multi_rdy, bad_rdy);
    end
  endtask

`ifdef FP_DIV_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    stub_mute = 1'b1;
    set_lane(3, 32'h40C00000, 32'h40000000);
    run_until(1, TMO + 60, 1'b0);
    checks++;
    if (rq.size() != 1 || gq.size() != 1) begin
      errors++;
      $display("FAIL tmo_count: rsp=%0d grants=%0d expected 1/1", rq.size(), gq.size());
    end else begin
      checks++;
      if (rq[0].oh !== 4'b1000 || rq[0].res !== 32'h7FC00000 || rq[0].err !== 1'b1 ||
          rq[0].cyc - gq[0].cyc != TMO + 2) begin
        errors++;
        $display("FAIL tmo_rsp: oh=%b res=%h err=%b dt=%0d expected 1000/7fc00000/1/%0d",
                 rq[0].oh, rq[0].res, rq[0].err, rq[0].cyc - gq[0].cyc, TMO + 2);
      end
    end
    stub_busy = 1'b0;
    stub_mute = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_alternate();
    test_ready_low();
    test_reset_wait();
    test_random();
`ifdef FP_DIV_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
